// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for the branch resolve controller: entry layout, FSM encoding, compare helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package branch_resolve_ctrl_pkg;

    localparam int XLEN    = 32;
    localparam int PRED_W  = 1;
    localparam int ENTRY_W = PRED_W + 2 * XLEN;   // {predict, pc, target}

    typedef struct packed {
        logic            predict;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // A taken prediction that goes to the wrong place is as bad as a wrong direction.
    function automatic logic is_mispredict(input pred_entry_t e,
                                           input logic        taken,
                                           input logic [XLEN-1:0] tgt);
        return (e.predict != taken) || (e.predict && taken && (e.target != tgt));
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of fetch push, execute resolve, predictor update, redirect and CSR signals.
// Latency: n/a (wiring only).
// Backpressure: fetch side is gated by fe_ready; execute side has no backpressure.
interface branch_resolve_ctrl_if;
    import branch_resolve_ctrl_pkg::*;

    // fetch side
    logic            fe_valid;
    logic            fe_predict;
    logic [XLEN-1:0] fe_pc;
    logic [XLEN-1:0] fe_target;
    logic            fe_ready;
    // execute side
    logic            ex_valid;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_is_cond;
    // predictor update / redirect
    logic            upd_valid;
    logic            upd_result;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    // status
    logic            err;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;

    // master: the pipeline around the controller
    modport master (
        output fe_valid, fe_predict, fe_pc, fe_target,
        output ex_valid, ex_taken, ex_target, ex_is_cond,
        input  fe_ready, upd_valid, upd_result, redirect, redirect_pc,
        input  err, branch_cnt, mispred_cnt
    );

    // slave: the controller itself
    modport slave (
        input  fe_valid, fe_predict, fe_pc, fe_target,
        input  ex_valid, ex_taken, ex_target, ex_is_cond,
        output fe_ready, upd_valid, upd_result, redirect, redirect_pc,
        output err, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/branch_resolve_ctrl_pred_fifo.sv
// Synchronous DEPTH-entry FIFO holding in-flight predictions; clear has priority over push/pop.
// Latency: push visible at head the cycle after the write edge; head_dat is combinational from rd_ptr.
// Backpressure: pushes while full and pops while empty are ignored; caller gates with count.
// Ports: clk, rst (async high), push/push_dat, pop, clear, head_dat, count.
module pred_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 65,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_dat,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (cnt < (PTR_W+1)'(DEPTH)) && !clear;
    assign do_pop   = pop && (cnt != '0) && !clear;
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Orders predicted branches, checks them against execute outcomes, strobes predictor update and redirects.
// Latency: update/redirect outputs one cycle after the resolving edge; counters visible the next cycle.
// Backpressure: fe_ready low when full or for FLUSH_CYCLES cycles after a redirect; execute is never stalled.
// Ports: clk, rst (async high), bus (slave side of branch_resolve_ctrl_if).
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_ctrl_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    state_t            state;
    state_t            state_nxt;
    logic [FC_W-1:0]   flush_cnt;
    logic [FC_W-1:0]   flush_cnt_nxt;

    logic [ENTRY_W-1:0] head_dat;
    pred_entry_t        head;
    pred_entry_t        push_entry;
    logic [PTR_W:0]     count;

    logic               in_run;
    logic               fe_ready;
    logic               do_push;
    logic               do_pop;
    logic               mispred;
    logic               err_set;
    logic [XLEN-1:0]    restart_pc;

    logic               upd_valid_q;
    logic               upd_result_q;
    logic               redirect_q;
    logic [XLEN-1:0]    redirect_pc_q;
    logic               err_q;
    logic [31:0]        branch_cnt_q;
    logic [31:0]        mispred_cnt_q;

    assign in_run = (state == RUN);

    // Held low during reset so every output reads 0 while rst is high.
    assign fe_ready = !rst && in_run && (count < (PTR_W+1)'(DEPTH));

    assign head       = pred_entry_t'(head_dat);
    assign push_entry = '{predict: bus.fe_predict, pc: bus.fe_pc, target: bus.fe_target};

    assign do_pop  = in_run && bus.ex_valid && (count != '0);
    assign mispred = do_pop && is_mispredict(head, bus.ex_taken, bus.ex_target);
    // A redirect squashes everything younger, including a push in the same cycle.
    assign do_push = bus.fe_valid && fe_ready && !mispred;

    assign err_set = (in_run && bus.ex_valid && (count == '0))
                   || (!in_run && bus.ex_valid)
                   || (in_run && bus.fe_valid && !fe_ready);

    assign restart_pc = bus.ex_taken ? bus.ex_target : (head.pc + 32'd4);

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_pred_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (do_push),
        .push_dat (push_entry),
        .pop      (do_pop),
        .clear    (mispred),
        .head_dat (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // FLUSH lasts exactly FLUSH_CYCLES cycles: loaded on entry, leave when it reads 1.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            RUN: begin
                if (mispred) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (flush_cnt == FC_W'(1)) begin
                    state_nxt     = RUN;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt     = RUN;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q   <= 1'b0;
            upd_result_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // JAL entries never train the direction predictor.
            upd_valid_q   <= do_pop && bus.ex_is_cond;
            upd_result_q  <= do_pop && bus.ex_is_cond && bus.ex_taken;
            redirect_q    <= mispred;
            redirect_pc_q <= mispred ? restart_pc : '0;
            if (err_set) err_q <= 1'b1;
            if (do_pop)  branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign bus.fe_ready    = fe_ready;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_result  = upd_result_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.err         = err_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: vector table plus hand sequences for full/err and reset-in-flush.
// Latency: checks registered outputs #1 after the edge, fe_ready #1 after driving inputs.
// Backpressure: stimulus respects fe_ready except where err is the expected outcome.
module tb_branch_resolve_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    branch_resolve_ctrl_if bus ();

    branch_resolve_ctrl #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic        fp;
        logic [31:0] fpc;
        logic [31:0] ftg;
        logic        ev;
        logic        et;
        logic [31:0] etg;
        logic        ec;
        logic        rdy;   // fe_ready before the edge
        logic        uv;    // remaining fields: after the edge
        logic        ur;
        logic        rd;
        logic [31:0] rpc;
        logic        er;
        logic [31:0] bc;
        logic [31:0] mc;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic fv, input logic fp, input logic [31:0] fpc,
                                input logic [31:0] ftg, input logic ev, input logic et,
                                input logic [31:0] etg, input logic ec, input logic rdy,
                                input logic uv, input logic ur, input logic rd,
                                input logic [31:0] rpc, input logic er,
                                input logic [31:0] bc, input logic [31:0] mc);
        vec_t v;
        v.fv = fv; v.fp = fp; v.fpc = fpc; v.ftg = ftg;
        v.ev = ev; v.et = et; v.etg = etg; v.ec = ec;
        v.rdy = rdy; v.uv = uv; v.ur = ur; v.rd = rd;
        v.rpc = rpc; v.er = er; v.bc = bc; v.mc = mc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic fp, input logic [31:0] fpc,
                         input logic [31:0] ftg, input logic ev, input logic et,
                         input logic [31:0] etg, input logic ec);
        bus.fe_valid   = fv;
        bus.fe_predict = fp;
        bus.fe_pc      = fpc;
        bus.fe_target  = ftg;
        bus.ex_valid   = ev;
        bus.ex_taken   = et;
        bus.ex_target  = etg;
        bus.ex_is_cond = ec;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " rst fe_ready"},    32'(bus.fe_ready),    32'h0);
        chk({tag, " rst upd_valid"},   32'(bus.upd_valid),   32'h0);
        chk({tag, " rst redirect"},    32'(bus.redirect),    32'h0);
        chk({tag, " rst err"},         32'(bus.err),         32'h0);
        chk({tag, " rst branch_cnt"},  bus.branch_cnt,       32'h0);
        chk({tag, " rst mispred_cnt"}, bus.mispred_cnt,      32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({tag, " post-rst fe_ready"}, 32'(bus.fe_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        idle();

        //           fv fp fpc            ftg           ev et etg         ec rdy uv ur rd rpc           er bc  mc
        vecs[0]  = mk(1, 1, 32'h80,       32'h200,      0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 0,  0);
        vecs[1]  = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h200,    1, 1,  1, 1, 0, 32'h0,        0, 1,  0);
        vecs[2]  = mk(1, 0, 32'h20,       32'h60,       0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 1,  0);
        vecs[3]  = mk(1, 1, 32'h24,       32'h70,       0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 1,  0);
        // push and correct not-taken resolve in the same cycle
        vecs[4]  = mk(1, 1, 32'h28,       32'h90,       1, 0, 32'h0,      1, 1,  1, 0, 0, 32'h0,        0, 2,  0);
        vecs[5]  = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h70,     1, 1,  1, 1, 0, 32'h0,        0, 3,  0);
        // correct JAL: counted, no update strobe
        vecs[6]  = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h90,     0, 1,  0, 0, 0, 32'h0,        0, 4,  0);
        // direction mispredict: restart at pc+4
        vecs[7]  = mk(1, 1, 32'h40,       32'h80,       0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 4,  0);
        vecs[8]  = mk(0, 0, 32'h0,        32'h0,        1, 0, 32'h0,      1, 1,  1, 0, 1, 32'h44,       0, 5,  1);
        vecs[9]  = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 5,  1);
        vecs[10] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 5,  1);
        vecs[11] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 5,  1);
        // JAL target mispredict
        vecs[12] = mk(1, 1, 32'h10,       32'h300,      0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 5,  1);
        vecs[13] = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h308,    0, 1,  0, 0, 1, 32'h308,      0, 6,  2);
        vecs[14] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 6,  2);
        vecs[15] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 6,  2);
        vecs[16] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 6,  2);
        // pc+4 wraps to 0
        vecs[17] = mk(1, 1, 32'hFFFFFFFC, 32'h1000,     0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 6,  2);
        vecs[18] = mk(0, 0, 32'h0,        32'h0,        1, 0, 32'h0,      1, 1,  1, 0, 1, 32'h0,        0, 7,  3);
        vecs[19] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 7,  3);
        vecs[20] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 7,  3);
        vecs[21] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 7,  3);
        // three entries, mispredict the oldest while fetch pushes a fourth
        vecs[22] = mk(1, 0, 32'h500,      32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 7,  3);
        vecs[23] = mk(1, 0, 32'h504,      32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 7,  3);
        vecs[24] = mk(1, 0, 32'h508,      32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 7,  3);
        vecs[25] = mk(1, 1, 32'h50C,      32'h0,        1, 1, 32'h600,    1, 1,  1, 1, 1, 32'h600,      0, 8,  4);
        vecs[26] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 8,  4);
        vecs[27] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 0,  0, 0, 0, 32'h0,        0, 8,  4);
        vecs[28] = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,      0, 1,  0, 0, 0, 32'h0,        0, 8,  4);
        // queue must be empty now: a resolve is a protocol error and pops nothing
        vecs[29] = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h0,      1, 1,  0, 0, 0, 32'h0,        1, 8,  4);

        do_reset("tbl");
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].fv, vecs[i].fp, vecs[i].fpc, vecs[i].ftg,
                  vecs[i].ev, vecs[i].et, vecs[i].etg, vecs[i].ec);
            #1;
            chk($sformatf("v%0d fe_ready", i), 32'(bus.fe_ready), 32'(vecs[i].rdy));
            step();
            chk($sformatf("v%0d upd_valid", i),   32'(bus.upd_valid),  32'(vecs[i].uv));
            chk($sformatf("v%0d upd_result", i),  32'(bus.upd_result), 32'(vecs[i].ur));
            chk($sformatf("v%0d redirect", i),    32'(bus.redirect),   32'(vecs[i].rd));
            if (vecs[i].rd)
                chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vecs[i].rpc);
            chk($sformatf("v%0d err", i),         32'(bus.err),        32'(vecs[i].er));
            chk($sformatf("v%0d branch_cnt", i),  bus.branch_cnt,      vecs[i].bc);
            chk($sformatf("v%0d mispred_cnt", i), bus.mispred_cnt,     vecs[i].mc);
        end
        idle();

        // Fill to DEPTH, then push once more while not ready.
        do_reset("full");
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            chk($sformatf("full push%0d fe_ready", k), 32'(bus.fe_ready), 32'h1);
            step();
        end
        idle();
        #1;
        chk("full fe_ready after 4", 32'(bus.fe_ready), 32'h0);
        chk("full err before 5th",   32'(bus.err),      32'h0);
        bus.fe_valid = 1'b1;
        step();
        idle();
        chk("full err after 5th", 32'(bus.err), 32'h1);
        // Entries are still the original four: resolving 0x100 as not-taken restarts at 0x104.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        idle();
        chk("full head redirect",    32'(bus.redirect), 32'h1);
        chk("full head redirect_pc", bus.redirect_pc,   32'h104);

        // ex_valid during FLUSH is an error and pops nothing.
        do_reset("flush_ev");
        drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        chk("flush_ev err before", 32'(bus.err), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        step();
        idle();
        chk("flush_ev err",        32'(bus.err),       32'h1);
        chk("flush_ev branch_cnt", bus.branch_cnt,     32'h1);
        chk("flush_ev upd_valid",  32'(bus.upd_valid), 32'h0);

        // Reset in the first FLUSH cycle, two counts remaining.
        do_reset("rst_flush");
        drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        idle();
        chk("rst_flush redirect pre",  32'(bus.redirect),  32'h1);
        chk("rst_flush upd_valid pre", 32'(bus.upd_valid), 32'h1);
        chk("rst_flush fe_ready pre",  32'(bus.fe_ready),  32'h0);
        rst = 1'b1;
        #1;
        chk("rst_flush redirect",    32'(bus.redirect),   32'h0);
        chk("rst_flush redirect_pc", bus.redirect_pc,     32'h0);
        chk("rst_flush upd_valid",   32'(bus.upd_valid),  32'h0);
        chk("rst_flush upd_result",  32'(bus.upd_result), 32'h0);
        chk("rst_flush fe_ready",    32'(bus.fe_ready),   32'h0);
        chk("rst_flush branch_cnt",  bus.branch_cnt,      32'h0);
        chk("rst_flush mispred_cnt", bus.mispred_cnt,     32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_flush fe_ready after", 32'(bus.fe_ready), 32'h1);
        step();
        chk("rst_flush fe_ready next",  32'(bus.fe_ready), 32'h1);
        chk("rst_flush err",            32'(bus.err),      32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
